rob_commit: RTL
===============

Name: rob_commit

Overview:
- In-order reorder buffer. Allocates a ROB index to each dispatched instruction and collects out-of-order writeback results from the CDB.
- Retires completed entries in program order onto the register-file commit interface: commit_regf_we/commit_rd_s/commit_rd_v/commit_rob, up to SUPERSCALAR per cycle.
- Sits between dispatch/issue and the RegFile_Scoreboard. Its commit_rob values are what the scoreboard compares against to clear pending tags.

Parameters:
- SUPERSCALAR, 1, max entries committed per cycle (1..4); sizes the unpacked commit arrays.
- ROB_DEPTH, 4, ROB index width; entry count = 2**ROB_DEPTH.
- CDB_PORTS, 1, number of writeback ports.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all entries
- disp_valid  in  1  dispatch request
- disp_rd_s  in  5  destination register
- disp_regf_we  in  1  instruction writes the register file
- disp_ready  out  1  entry available (not full)
- disp_rob  out  ROB_DEPTH  index allocated to the current dispatch
- cdb_valid[CDB_PORTS]  in  1  writeback strobe
- cdb_rob[CDB_PORTS]  in  ROB_DEPTH  completing entry
- cdb_value[CDB_PORTS]  in  32  result
- commit_regf_we[SUPERSCALAR]  out  1  slot writes the register file
- commit_rd_s[SUPERSCALAR]  out  5  destination register
- commit_rd_v[SUPERSCALAR]  out  32  value
- commit_rob[SUPERSCALAR]  out  ROB_DEPTH  retiring index
- commit_valid[SUPERSCALAR]  out  1  slot retires this cycle (includes non-writing instructions)
- rob_count  out  ROB_DEPTH+1  occupied entries
- rob_empty  out  1  no entries

Behaviour:
- Storage and pointers:
  - Per-entry fields: valid, done, regf_we, rd_s, value.
  - head/tail are ROB_DEPTH+1 bits; the MSB is the wrap bit.
  - empty when head==tail; full when the index bits are equal and the wrap bits differ.
  - rob_count = tail-head, modulo 2**(ROB_DEPTH+1).
- Reset (rst low, asynchronous): all entry valid/done = 0, head = tail = 0. Outputs: disp_ready=1, disp_rob=0, rob_count=0, rob_empty=1, all commit_* = 0.
- Dispatch:
  - disp_ready = !full. disp_rob = tail index (combinational).
  - On disp_valid & disp_ready: write the entry {valid=1, done=0, rd_s, regf_we} and increment tail.
  - disp_valid while full is ignored; the requester holds.
  - A commit in the same cycle does not raise disp_ready (no full bypass).
- Writeback:
  - On cdb_valid[j]: if entry[cdb_rob[j]].valid, set done=1 and value=cdb_value[j].
  - Writeback to an invalid entry is dropped.
  - Two ports hitting the same index in one cycle: the higher j wins.
- Commit:
  - Combinational from registered state only; there is no input-to-output path.
  - Slot i examines entry head+i. commit_valid[i] = entry valid & done & commit_valid[i-1] (slot 0: no predecessor term).
  - commit_regf_we[i] = commit_valid[i] & regf_we. commit_rd_s, commit_rd_v and commit_rob are driven only when commit_valid[i], and are 0 otherwise.
  - At the clock edge, committed entries get valid=0 and head advances by popcount(commit_valid).
- Latency:
  - A writeback at edge N sets done.
  - The earliest commit of that entry is asserted during cycle N+1; head moves at edge N+1.
  - A same-cycle writeback to the head entry does not commit that cycle.
- Ordering: same-index register writes in one commit group appear in slot order; the regfile's slot loop gives the younger slot priority.
- Flush (synchronous): clears all valid/done and sets head = tail = 0. Overrides dispatch, writeback and commit in that cycle; commit outputs for that cycle are still driven from the pre-flush state.
- Wrap: the index wraps modulo 2**ROB_DEPTH. Commit slots that wrap past the last entry index correctly; slots beyond tail see valid=0.

Optional Feature:
- Macro: ROB_FWD_EN.
- When defined, adds 2*SUPERSCALAR read ports: fwd_rob[k] (in, ROB_DEPTH) returning fwd_ready[k] (out, 1) and fwd_value[k] (out, 32), combinationally from entry state.
  - fwd_ready = valid & done. fwd_value = value when ready, else 0.
  - Lets issue resolve operands whose scoreboard tag points at a completed but not yet committed entry.
- When undefined, the ports do not exist and no read muxes are built.

Test Plan:
- Reset, then dispatch 3 instructions (rd 1,2,3, we=1) -> disp_rob 0,1,2; rob_count=3; no commit_valid.
- Writeback rob2=0xC, then rob0=0xA, then rob1=0xB on successive cycles:
  - rob0 commits alone (rd1=0xA) the cycle after its writeback.
  - rob1 and rob2 commit the cycle after rob1's writeback (SUPERSCALAR=2: same cycle; =1: consecutive cycles) -> rd2=0xB then rd3=0xC; rob_empty=1 afterwards.
- Fill all 2**ROB_DEPTH entries -> disp_ready=0, and a further disp_valid is not allocated. Commit one entry -> disp_ready=1 the next cycle; the new disp_rob equals the freed index (wrap).
- Dispatch a store (we=0) -> commit_valid=1 with commit_regf_we=0. Writeback to an unallocated index -> no state change.
- Flush with 5 entries, 2 of them done -> the next cycle rob_count=0, disp_rob=0, no commits. Assert rst mid-commit -> all outputs return to reset values immediately, without a clock edge.
- ROB_FWD_EN: entry 4 done with 0x55 -> fwd_rob=4 gives fwd_ready=1, fwd_value=0x55; for a not-done entry fwd_ready=0.

Source files
------------

// File: rtl/rob_commit_if.sv
// Dispatch / writeback / commit bundle for the in-order reorder buffer.
// Optional forwarding read ports appear when ROB_FWD_EN is defined.
interface rob_commit_if #(
    parameter int SUPERSCALAR = 1,
    parameter int ROB_DEPTH   = 4,
    parameter int CDB_PORTS   = 1
);
    logic                 flush;
    logic                 disp_valid;
    logic [4:0]           disp_rd_s;
    logic                 disp_regf_we;
    logic                 disp_ready;
    logic [ROB_DEPTH-1:0] disp_rob;
    logic                 cdb_valid      [CDB_PORTS];
    logic [ROB_DEPTH-1:0] cdb_rob        [CDB_PORTS];
    logic [31:0]          cdb_value      [CDB_PORTS];
    logic                 commit_regf_we [SUPERSCALAR];
    logic [4:0]           commit_rd_s    [SUPERSCALAR];
    logic [31:0]          commit_rd_v    [SUPERSCALAR];
    logic [ROB_DEPTH-1:0] commit_rob     [SUPERSCALAR];
    logic                 commit_valid   [SUPERSCALAR];
    logic [ROB_DEPTH:0]   rob_count;
    logic                 rob_empty;
`ifdef ROB_FWD_EN
    logic [ROB_DEPTH-1:0] fwd_rob        [2*SUPERSCALAR];
    logic                 fwd_ready      [2*SUPERSCALAR];
    logic [31:0]          fwd_value      [2*SUPERSCALAR];

    modport slave (
        input  flush, disp_valid, disp_rd_s, disp_regf_we, cdb_valid, cdb_rob, cdb_value, fwd_rob,
        output disp_ready, disp_rob, commit_regf_we, commit_rd_s, commit_rd_v, commit_rob,
               commit_valid, rob_count, rob_empty, fwd_ready, fwd_value
    );
    modport master (
        output flush, disp_valid, disp_rd_s, disp_regf_we, cdb_valid, cdb_rob, cdb_value, fwd_rob,
        input  disp_ready, disp_rob, commit_regf_we, commit_rd_s, commit_rd_v, commit_rob,
               commit_valid, rob_count, rob_empty, fwd_ready, fwd_value
    );
`else
    modport slave (
        input  flush, disp_valid, disp_rd_s, disp_regf_we, cdb_valid, cdb_rob, cdb_value,
        output disp_ready, disp_rob, commit_regf_we, commit_rd_s, commit_rd_v, commit_rob,
               commit_valid, rob_count, rob_empty
    );
    modport master (
        output flush, disp_valid, disp_rd_s, disp_regf_we, cdb_valid, cdb_rob, cdb_value,
        input  disp_ready, disp_rob, commit_regf_we, commit_rd_s, commit_rd_v, commit_rob,
               commit_valid, rob_count, rob_empty
    );
`endif
endinterface

// File: rtl/rob_commit.sv
// In-order reorder buffer: allocates indices at dispatch, collects CDB results,
// retires up to SUPERSCALAR entries per cycle in order. ROB_FWD_EN adds operand read ports.
module rob_commit #(
    parameter int SUPERSCALAR = 1,
    parameter int ROB_DEPTH   = 4,
    parameter int CDB_PORTS   = 1
) (
    input  logic          clk,
    input  logic          rst,
    rob_commit_if.slave   bus
);
    localparam int ENTRIES = 1 << ROB_DEPTH;
    localparam int PW      = ROB_DEPTH + 1;

    logic [ENTRIES-1:0]   valid_r;
    logic [ENTRIES-1:0]   done_r;
    logic [ENTRIES-1:0]   we_r;
    logic [4:0]           rd_r    [ENTRIES];
    logic [31:0]          value_r [ENTRIES];
    logic [PW-1:0]        head_r;
    logic [PW-1:0]        tail_r;

    logic                 full_s;
    logic                 disp_fire_s;
    logic                 cv_s       [SUPERSCALAR];
    logic [ROB_DEPTH-1:0] slot_idx_s [SUPERSCALAR];
    logic [PW-1:0]        n_commit_s;

    assign full_s      = (head_r[ROB_DEPTH-1:0] == tail_r[ROB_DEPTH-1:0]) &&
                         (head_r[ROB_DEPTH] != tail_r[ROB_DEPTH]);
    assign disp_fire_s = bus.disp_valid & ~full_s;

    // Commit chain: slot i retires only if every older slot retires too
    always_comb begin
        logic chain;
        chain      = 1'b1;
        n_commit_s = '0;
        for (int i = 0; i < SUPERSCALAR; i++) begin
            slot_idx_s[i] = head_r[ROB_DEPTH-1:0] + ROB_DEPTH'(i);
            cv_s[i]       = chain & valid_r[slot_idx_s[i]] & done_r[slot_idx_s[i]];
            chain         = cv_s[i];
            n_commit_s    = n_commit_s + PW'(cv_s[i]);
        end
    end

    // Commit slot outputs are zeroed whenever the slot is not retiring
    always_comb begin
        for (int i = 0; i < SUPERSCALAR; i++) begin
            bus.commit_valid[i]   = cv_s[i];
            bus.commit_regf_we[i] = cv_s[i] & we_r[slot_idx_s[i]];
            bus.commit_rd_s[i]    = cv_s[i] ? rd_r[slot_idx_s[i]]    : 5'd0;
            bus.commit_rd_v[i]    = cv_s[i] ? value_r[slot_idx_s[i]] : 32'd0;
            bus.commit_rob[i]     = cv_s[i] ? slot_idx_s[i]          : {ROB_DEPTH{1'b0}};
        end
    end

    // Occupancy and allocation status
    always_comb begin
        bus.disp_ready = ~full_s;
        bus.disp_rob   = tail_r[ROB_DEPTH-1:0];
        bus.rob_count  = tail_r - head_r;
        bus.rob_empty  = (head_r == tail_r);
    end

    // Entry state and pointers; commit clears come last so they win over a late writeback
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= '0;
            done_r  <= '0;
            we_r    <= '0;
            head_r  <= '0;
            tail_r  <= '0;
            for (int e = 0; e < ENTRIES; e++) begin
                rd_r[e]    <= 5'd0;
                value_r[e] <= 32'd0;
            end
        end else if (bus.flush) begin
            valid_r <= '0;
            done_r  <= '0;
            head_r  <= '0;
            tail_r  <= '0;
        end else begin
            if (disp_fire_s) begin
                valid_r[tail_r[ROB_DEPTH-1:0]] <= 1'b1;
                done_r[tail_r[ROB_DEPTH-1:0]]  <= 1'b0;
                we_r[tail_r[ROB_DEPTH-1:0]]    <= bus.disp_regf_we;
                rd_r[tail_r[ROB_DEPTH-1:0]]    <= bus.disp_rd_s;
                tail_r                         <= tail_r + PW'(1);
            end
            for (int j = 0; j < CDB_PORTS; j++) begin
                if (bus.cdb_valid[j] && valid_r[bus.cdb_rob[j]]) begin
                    done_r[bus.cdb_rob[j]]  <= 1'b1;
                    value_r[bus.cdb_rob[j]] <= bus.cdb_value[j];
                end
            end
            for (int i = 0; i < SUPERSCALAR; i++) begin
                if (cv_s[i]) begin
                    valid_r[slot_idx_s[i]] <= 1'b0;
                    done_r[slot_idx_s[i]]  <= 1'b0;
                end
            end
            head_r <= head_r + n_commit_s;
        end
    end

`ifdef ROB_FWD_EN
    // Operand forwarding from completed, not yet retired entries
    always_comb begin
        for (int k = 0; k < 2*SUPERSCALAR; k++) begin
            bus.fwd_ready[k] = valid_r[bus.fwd_rob[k]] & done_r[bus.fwd_rob[k]];
            bus.fwd_value[k] = (valid_r[bus.fwd_rob[k]] & done_r[bus.fwd_rob[k]]) ?
                               value_r[bus.fwd_rob[k]] : 32'd0;
        end
    end
`endif

endmodule
